// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - default geometry and stage-count helper for pipe_adder
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG   = 4;

    function automatic int calc_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// rtl/pipe_adder_seg.sv - one SEG-bit carry segment used by every pipe_adder stage
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_ci,
    output logic [SEG-1:0] o_s,
    output logic           o_co,
    output logic           o_ov
);

    logic [SEG:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_ci};
    assign o_s   = w_sum[SEG-1:0];
    assign o_co  = w_sum[SEG];
    // Signed overflow: operands agree in sign and the segment MSB disagrees with them.
    assign o_ov  = (i_a[SEG-1] ~^ i_b[SEG-1]) & (o_s[SEG-1] ^ i_a[SEG-1]);

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented carry-pipelined adder/subtractor with valid/ready flow control
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    if (WIDTH % SEG != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of SEG");
    end

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;

    logic             w_en;
    logic             w_v_src   [STAGES];
    logic [WIDTH-1:0] w_a_src   [STAGES];
    logic [WIDTH-1:0] w_b_src   [STAGES];
    logic [WIDTH-1:0] w_sum_src [STAGES];
    logic             w_c_src   [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];
    logic [SEG-1:0]   w_seg_s   [STAGES];
    logic             w_seg_co  [STAGES];
    logic             w_seg_ov  [STAGES];

    assign w_en     = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_en;

    // Operands travel right-aligned so each stage always adds the low SEG bits;
    // finished segments enter the sum from the top and settle in place after STAGES shifts.
    always_comb begin
        w_v_src[0]   = in_valid;
        w_a_src[0]   = a;
        w_b_src[0]   = sub ? ~b : b;
        w_c_src[0]   = sub ? 1'b1 : cin;
        w_sum_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_src[k]   = r_vld[k-1];
            w_a_src[k]   = r_a[k-1];
            w_b_src[k]   = r_b[k-1];
            w_c_src[k]   = r_c[k-1];
            w_sum_src[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_sum_nxt[k] = (w_sum_src[k] >> SEG) | (WIDTH'(w_seg_s[k]) << (WIDTH - SEG));
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_seg #(.SEG(SEG)) u_seg (
            .i_a  (w_a_src[k][SEG-1:0]),
            .i_b  (w_b_src[k][SEG-1:0]),
            .i_ci (w_c_src[k]),
            .o_s  (w_seg_s[k]),
            .o_co (w_seg_co[k]),
            .o_ov (w_seg_ov[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_src[k];
                r_a[k]   <= w_a_src[k] >> SEG;
                r_b[k]   <= w_b_src[k] >> SEG;
                r_sum[k] <= w_sum_nxt[k];
                r_c[k]   <= w_seg_co[k];
            end
            r_ovf <= w_seg_ov[STAGES-1];
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign s         = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder at SEG=4, 16 and 1
module tb_pipe_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, input logic vs);
        exp_t         e;
        logic [W-1:0] beff;
        int unsigned  tot;
        int           sv;
        beff  = vs ? ~vb : vb;
        tot   = 32'(va) + 32'(beff) + (vs ? 32'd1 : 32'(vc));
        sv    = int'($signed(va)) + int'($signed(beff)) + (vs ? 1 : int'(vc));
        e.s    = tot[W-1:0];
        e.cout = tot[W];
        e.ovf  = (sv > 32767) || (sv < -32768);
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int SEG    = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        localparam int STAGES = W / SEG;

        logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, s;
        exp_t         q[$];
        int           adv_d = 0;
        logic         rdy_s = 1'b0;
        logic         acc_s = 1'b0;
        logic         use_fix = 1'b0;
        exp_t         fix;

        pipe_adder #(.WIDTH(W), .SEG(SEG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .s         (s),
            .cout      (cout),
            .ovf       (ovf)
        );

        // One cycle: observe the handshake at negedge, then move to just after the next posedge.
        task automatic step();
            exp_t e;
            @(negedge clk);
            rdy_s = in_ready;
            acc_s = rst_n && in_valid && in_ready;
            if (in_ready) adv_d++;
            if (acc_s) begin
                e     = use_fix ? fix : model(a, b, cin, sub);
                e.acc = adv_d;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic vs);
            int n;
            n = 0;
            in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs;
            do begin
                step();
                n++;
            end while (!acc_s && n < 50);
            chk($sformatf("seg%0d send accepted", SEG), acc_s, 1);
            in_valid = 1'b0;
        endtask

        task automatic send_fix(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                                input logic vs, input logic [W-1:0] es, input logic ec,
                                input logic eo);
            fix.s = es; fix.cout = ec; fix.ovf = eo; fix.acc = 0;
            use_fix = 1'b1;
            send(va, vb, vc, vs);
            use_fix = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while (q.size() != 0 && n < 200) begin
                step();
                n++;
            end
            chk($sformatf("seg%0d drain empty", SEG), q.size(), 0);
        endtask

        initial begin : driver
            int i, t, acc, cyc;
            rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            out_ready = 1'b1;
            #1;
            chk($sformatf("seg%0d reset out_valid", SEG), out_valid, 0);
            chk($sformatf("seg%0d reset s", SEG), s, 0);
            chk($sformatf("seg%0d reset in_ready", SEG), in_ready, 1);
            step();
            step();
            rst_n = 1'b1;
            step();

            send_fix(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            drain();
            send_fix(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            send_fix(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
            send_fix(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
            send_fix(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
            send_fix(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
            drain();

            // Eight back-to-back pairs with a three-cycle consumer stall once results appear.
            i = 0;
            t = 0;
            while ((i < 8 || t < STAGES + 3) && t < 200) begin
                in_valid  = (i < 8);
                a = rnd_op(); b = rnd_op(); cin = 1'($urandom); sub = 1'($urandom);
                out_ready = !(t >= STAGES && t < STAGES + 3);
                step();
                if (!out_ready) chk($sformatf("seg%0d stall in_ready", SEG), rdy_s, 0);
                if (acc_s) i++;
                t++;
            end
            in_valid = 1'b0;
            chk($sformatf("seg%0d stream accepted", SEG), i, 8);
            drain();

            // Reset with results in flight: nothing from before reset may appear.
            for (int j = 0; j < 3; j++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            rst_n = 1'b0;
            q.delete();
            #1;
            chk($sformatf("seg%0d async reset out_valid", SEG), out_valid, 0);
            chk($sformatf("seg%0d reset in_ready", SEG), in_ready, 1);
            step();
            rst_n = 1'b1;
            repeat (2) begin
                step();
                chk($sformatf("seg%0d post-reset out_valid", SEG), out_valid, 0);
            end
            send_fix(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
            drain();

            acc = 0;
            cyc = 0;
            while (acc < 10000 && cyc < 40000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                a = rnd_op(); b = rnd_op(); cin = 1'($urandom); sub = 1'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                step();
                if (acc_s) acc++;
                cyc++;
            end
            chk($sformatf("seg%0d random accepted", SEG), acc, 10000);
            drain();
            done_cnt++;
        end

        initial begin : monitor
            bit   fresh;
            int   adv_m;
            exp_t e;
            fresh = 1'b0;
            adv_m = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk($sformatf("seg%0d in-reset out_valid", SEG), out_valid, 0);
                    chk($sformatf("seg%0d in-reset cout/ovf/s", SEG), {cout, ovf, s}, 0);
                    fresh = 1'b0;
                end else begin
                    // An advance that leaves out_valid high always brings a new result.
                    if (fresh && out_valid) begin
                        chk($sformatf("seg%0d result expected", SEG), (q.size() != 0), 1);
                        if (q.size() != 0)
                            chk($sformatf("seg%0d latency", SEG), adv_m - q[0].acc + 1, STAGES);
                    end
                    if (out_valid && out_ready && q.size() != 0) begin
                        e = q.pop_front();
                        chk($sformatf("seg%0d s", SEG), s, e.s);
                        chk($sformatf("seg%0d cout", SEG), cout, e.cout);
                        chk($sformatf("seg%0d ovf", SEG), ovf, e.ovf);
                    end
                    fresh = in_ready;
                end
                if (in_ready) adv_m++;
            end
        end
    end

    initial begin
        fork
            wait (done_cnt == 3);
            #800000;
        join_any
        if (done_cnt != 3) begin
            n_checks++;
            n_errors++;
            $display("FAIL completion: got %0d configs done expected 3", done_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter SEG, default 4: bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  operand set accepted this cycle when in_valid=1.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  1 = subtract (A - B), 0 = add (A + B + cin).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result this cycle when out_valid=1.
REQ-013 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Result SHALL equal a + (sub ? ~b : b) + (sub ? 1 : cin), WIDTH+1 bits, s = low WIDTH bits, cout = bit WIDTH.
REQ-017 ovf SHALL be 1 iff both effective operands share a sign bit and s sign differs from it.
REQ-018 Stage k (0..STAGES-1) SHALL add segment k of the operands plus carry from stage k-1 (stage 0: effective cin) and register the segment sum, the carry, and all not-yet-added upper operand segments.
REQ-019 Latency SHALL be exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stall.
REQ-020 Pipeline advance enable en = !out_valid | out_ready; in_ready SHALL equal en, combinationally.
REQ-021 When en=0, every stage, including valid bits and data, SHALL hold.
REQ-022 Per-stage valid bits SHALL shift with en; a bubble (in_valid=0 on advance) SHALL propagate as an invalid stage, not collapsed.
REQ-023 Throughput SHALL be one result per cycle when out_ready stays high.
REQ-024 Results SHALL emerge in accept order; none dropped or duplicated under any out_ready pattern.
REQ-025 sub, cin and operands SHALL be sampled only at accept; later input changes SHALL not affect in-flight results.
REQ-026 When SEG = WIDTH, SHALL degenerate to a single registered stage, latency 1.
REQ-027 WIDTH not a multiple of SEG SHALL be rejected at elaboration.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, s=0, cout=0, ovf=0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; first output after release only from operands accepted after release.
REQ-030 in_ready SHALL be 1 during and right after reset (pipeline empty).

Structure
REQ-031 Package pipe_adder_pkg SHALL hold default WIDTH/SEG constants and the STAGES computation function.
REQ-032 One sub-module adder_seg SHALL implement a SEG-bit combinational ripple segment (a, b, ci -> s, co, overflow of MSB), instantiated once per stage.
REQ-033 Output registers SHALL be the final stage registers; no combinational path from a/b to s.

Verification (WIDTH=16, SEG=4)
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> s=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-035 a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0, ovf=0; a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, ovf=1.
REQ-036 Stream 8 back-to-back operand pairs, out_ready low for 3 cycles mid-stream -> in_ready low for those cycles, all 8 results correct and in order.
REQ-037 Accept 3 operand pairs, assert rst_n low for 1 cycle before any result -> out_valid stays 0; new pair after release yields its result at latency 4.
REQ-038 Random 10k vectors with random in_valid/out_ready against a+b+cin reference model; repeat with SEG=16 (latency 1) and SEG=1 (latency 16).
